// File: rtl/capture_trigger_ctrl_pkg.sv
// Shared state and trigger-mode codes for the capture trigger controller.
// The register map decodes state_o and trig_mode_i with these same values.
package capture_trigger_ctrl_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_OFFSET  = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      TRIG_RISE = 2'b00,
      TRIG_FALL = 2'b01,
      TRIG_HIGH = 2'b10,
      TRIG_LOW  = 2'b11
   } trig_mode_t;

endpackage

// File: rtl/capture_trigger_ctrl_if.sv
// Control/status bundle between the register layer (master) and the capture trigger controller (slave).
interface capture_trigger_ctrl_if #(
   parameter int CNT_W = 32
);
   // Protocol: a rising arm_i starts one capture sequence; adc_capture_go stays high for the whole
   // capture until adc_capture_stop is honoured; arm_i low aborts or releases the sequence at any time.
   logic             arm_i;
   logic [1:0]       trig_mode_i;
   logic             trigger_i;
   logic             trigger_now_i;
   logic [CNT_W-1:0] offset_i;
   logic [CNT_W-1:0] timeout_i;
   logic             adc_capture_stop;
   logic             adc_capture_go;
   logic             adc_trig_status;
   logic             armed_o;
   logic             capture_done_o;
   logic             timed_out_o;
   logic [2:0]       state_o;

   modport master (
      output arm_i, trig_mode_i, trigger_i, trigger_now_i, offset_i, timeout_i, adc_capture_stop,
      input  adc_capture_go, adc_trig_status, armed_o, capture_done_o, timed_out_o, state_o
   );

   modport slave (
      input  arm_i, trig_mode_i, trigger_i, trigger_now_i, offset_i, timeout_i, adc_capture_stop,
      output adc_capture_go, adc_trig_status, armed_o, capture_done_o, timed_out_o, state_o
   );
endinterface

// File: rtl/capture_trigger_ctrl_detect.sv
// Trigger front end: synchronizes the external trigger pin, detects edges and
// selects the hit condition for the current trigger mode.
module capture_trigger_ctrl_detect
   import capture_trigger_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       trigger,
   input  logic       force_trig,
   input  logic [1:0] mode,
   output logic       status,
   output logic       hit
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   rise_q;
   logic                   fall_q;
   logic                   mode_hit;

   // Edges are registered, so edge modes see the pin one cycle later than level modes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], trigger};
         prev_q <= sync_q[SYNC_STAGES-1];
         rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
         fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
      end
   end

   assign status = sync_q[SYNC_STAGES-1];

   always_comb begin
      mode_hit = 1'b0;
      case (trig_mode_t'(mode))
         TRIG_RISE: mode_hit = rise_q;
         TRIG_FALL: mode_hit = fall_q;
         TRIG_HIGH: mode_hit = status;
         TRIG_LOW:  mode_hit = ~status;
         default:   mode_hit = 1'b0;
      endcase
   end

   assign hit = mode_hit | force_trig;

endmodule

// File: rtl/capture_trigger_ctrl.sv
// Capture sequencer: arm, wait for trigger or timeout, optional post-trigger offset,
// then hold adc_capture_go until the FIFO path reports stop.
module capture_trigger_ctrl
   import capture_trigger_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 32,
   parameter int STOP_BLANK  = 2
) (
   input logic                  adc_sampleclk,
   input logic                  reset_i,
   capture_trigger_ctrl_if.slave bus
);

   localparam int                 BLANK_W    = $clog2(STOP_BLANK + 2);
   localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(STOP_BLANK);
   localparam logic [BLANK_W-1:0] BLANK_ONE  = BLANK_W'(1);
   localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

   state_t             state_q;
   state_t             state_d;
   logic               arm_q;
   logic [CNT_W-1:0]   to_cnt_q;
   logic [CNT_W-1:0]   off_cnt_q;
   logic [BLANK_W-1:0] blank_q;
   logic               go_q;
   logic               timed_out_q;

   logic               trig_status;
   logic               trig_hit;
   logic               arm_rise;
   logic               timeout_hit;
   logic               timeout_fire;
   logic               blank_done;
   logic               enter_capture;

   capture_trigger_ctrl_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_detect (
      .clk        (adc_sampleclk),
      .rst        (reset_i),
      .trigger    (bus.trigger_i),
      .force_trig (bus.trigger_now_i),
      .mode       (bus.trig_mode_i),
      .status     (trig_status),
      .hit        (trig_hit)
   );

   assign arm_rise      = bus.arm_i & ~arm_q;
   assign timeout_hit   = (bus.timeout_i != '0) && (to_cnt_q == bus.timeout_i - CNT_ONE);
   assign blank_done    = (blank_q >= BLANK_LAST);
   assign enter_capture = (state_d == ST_CAPTURE) && (state_q != ST_CAPTURE);

   // arm_i low has priority over every forward transition.
   always_comb begin
      state_d      = state_q;
      timeout_fire = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (arm_rise) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (!bus.arm_i) begin
               state_d = ST_IDLE;
            end else if (trig_hit || timeout_hit) begin
               state_d      = (bus.offset_i != '0) ? ST_OFFSET : ST_CAPTURE;
               timeout_fire = ~trig_hit;
            end
         end
         ST_OFFSET: begin
            if (!bus.arm_i)            state_d = ST_IDLE;
            else if (off_cnt_q == '0)  state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (!bus.arm_i)                                 state_d = ST_IDLE;
            else if (blank_done && bus.adc_capture_stop)    state_d = ST_DONE;
         end
         ST_DONE: begin
            if (!bus.arm_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge adc_sampleclk or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         arm_q       <= 1'b0;
         to_cnt_q    <= '0;
         off_cnt_q   <= '0;
         blank_q     <= '0;
         go_q        <= 1'b0;
         timed_out_q <= 1'b0;
      end else begin
         state_q <= state_d;
         arm_q   <= bus.arm_i;
         go_q    <= (state_d == ST_CAPTURE);

         if (state_q == ST_IDLE && state_d == ST_ARMED) begin
            to_cnt_q    <= '0;
            timed_out_q <= 1'b0;
         end else if (state_q == ST_ARMED && to_cnt_q != '1) begin
            to_cnt_q <= to_cnt_q + CNT_ONE;
         end

         if (timeout_fire) timed_out_q <= 1'b1;

         // Offset is latched on leaving ARMED and then counted down to zero.
         if (state_q == ST_ARMED && state_d == ST_OFFSET) begin
            off_cnt_q <= bus.offset_i - CNT_ONE;
         end else if (state_q == ST_OFFSET && off_cnt_q != '0) begin
            off_cnt_q <= off_cnt_q - CNT_ONE;
         end

         if (enter_capture) begin
            blank_q <= '0;
         end else if (state_q == ST_CAPTURE && !blank_done) begin
            blank_q <= blank_q + BLANK_ONE;
         end
      end
   end

   assign bus.adc_capture_go  = go_q;
   assign bus.adc_trig_status = trig_status;
   assign bus.armed_o         = (state_q == ST_ARMED) || (state_q == ST_OFFSET);
   assign bus.capture_done_o  = (state_q == ST_DONE);
   assign bus.timed_out_o     = timed_out_q;
   assign bus.state_o         = state_q;

endmodule

// File: tb/tb_capture_trigger_ctrl.sv
// Bench for capture_trigger_ctrl: directed and randomized capture sequences checked
// against a timeline model built from trigger, offset, timeout, stop and abort times.
module tb_capture_trigger_ctrl;

   localparam int     CNT_W = 32;
   localparam int     SYNC  = 2;
   localparam int     BLANK = 2;
   localparam longint NEVER = 64'sd1099511627776;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ARMED   = 3'd1;
   localparam logic [2:0] S_OFFSET  = 3'd2;
   localparam logic [2:0] S_CAPTURE = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic tout_carry = 1'b0;

   always #5 clk = ~clk;

   capture_trigger_ctrl_if #(.CNT_W(CNT_W)) bus ();

   capture_trigger_ctrl #(
      .SYNC_STAGES (SYNC),
      .CNT_W       (CNT_W),
      .STOP_BLANK  (BLANK)
   ) dut (
      .adc_sampleclk (clk),
      .reset_i       (rst),
      .bus           (bus)
   );

   function automatic longint min2(input longint a, input longint b);
      return (a < b) ? a : b;
   endfunction

   function automatic longint max2(input longint a, input longint b);
      return (a > b) ? a : b;
   endfunction

   // Arm at negedge 0; every event time is the negedge at which it is driven.
   task automatic run_scenario(input string name, input logic [1:0] mode, input bit pre,
                               input longint pin_t, input longint now_t, input longint offset,
                               input longint timeout, input longint stop_s, input longint abort_a,
                               input longint ncyc_fix);
      longint     t_trig, t_to, e, c, d, a, ncyc;
      bit         tout, level_mode;
      logic       lvl_on, lvl_off, exp_tout, exp_status;
      logic [2:0] exp_state;
      level_mode = mode[1];
      lvl_on     = (mode == 2'b00 || mode == 2'b10);
      lvl_off    = ~lvl_on;

      t_trig = NEVER;
      if (pin_t >= 0) t_trig = min2(t_trig, level_mode ? pin_t + SYNC + 1 : pin_t + SYNC + 2);
      if (pre && level_mode) t_trig = min2(t_trig, 2);
      if (now_t >= 0) t_trig = min2(t_trig, now_t + 1);
      t_to = (timeout != 0) ? timeout + 1 : NEVER;
      e    = min2(t_trig, t_to);
      tout = (t_to < t_trig);
      c    = (e < NEVER) ? e + offset : NEVER;
      d    = (stop_s >= 0 && c < NEVER) ? c + max2(max2(stop_s - c, 0), BLANK) + 1 : NEVER;
      a    = (abort_a >= 0) ? abort_a + 1 : NEVER;
      if (ncyc_fix > 0)               ncyc = ncyc_fix;
      else if (min2(a, d) < NEVER)    ncyc = min2(a, d) + 3;
      else                            ncyc = 120;

      @(negedge clk);
      bus.arm_i            = 1'b0;
      bus.trigger_now_i    = 1'b0;
      bus.adc_capture_stop = 1'b0;
      bus.trig_mode_i      = mode;
      bus.offset_i         = offset[CNT_W-1:0];
      bus.timeout_i        = timeout[CNT_W-1:0];
      bus.trigger_i        = pre ? lvl_on : lvl_off;
      repeat (5) @(negedge clk);

      exp_tout = tout_carry;
      for (longint n = 0; n <= ncyc; n++) begin
         if (n > 0) @(negedge clk);
         if (n >= a || n < 1) exp_state = S_IDLE;
         else if (n < e)      exp_state = S_ARMED;
         else if (n < c)      exp_state = S_OFFSET;
         else if (n < d)      exp_state = S_CAPTURE;
         else                 exp_state = S_DONE;
         if (n == 0) exp_tout = tout_carry;
         else        exp_tout = tout && (e < a) && (n >= e);
         exp_status = (pre || (pin_t >= 0 && n >= pin_t + SYNC)) ? lvl_on : lvl_off;

         checks++;
         if (bus.state_o !== exp_state) begin
            errors++;
            $display("FAIL %s state n=%0d got %0d exp %0d", name, n, bus.state_o, exp_state);
         end
         checks++;
         if (bus.adc_capture_go !== (exp_state == S_CAPTURE)) begin
            errors++;
            $display("FAIL %s go n=%0d got %b exp %b", name, n, bus.adc_capture_go, exp_state == S_CAPTURE);
         end
         checks++;
         if (bus.armed_o !== (exp_state == S_ARMED || exp_state == S_OFFSET)) begin
            errors++;
            $display("FAIL %s armed n=%0d got %b exp %b", name, n, bus.armed_o,
                     exp_state == S_ARMED || exp_state == S_OFFSET);
         end
         checks++;
         if (bus.capture_done_o !== (exp_state == S_DONE)) begin
            errors++;
            $display("FAIL %s done n=%0d got %b exp %b", name, n, bus.capture_done_o, exp_state == S_DONE);
         end
         checks++;
         if (bus.timed_out_o !== exp_tout) begin
            errors++;
            $display("FAIL %s timed_out n=%0d got %b exp %b", name, n, bus.timed_out_o, exp_tout);
         end
         checks++;
         if (bus.adc_trig_status !== exp_status) begin
            errors++;
            $display("FAIL %s trig_status n=%0d got %b exp %b", name, n, bus.adc_trig_status, exp_status);
         end

         if (n == 0)          bus.arm_i = 1'b1;
         if (n == pin_t)      bus.trigger_i = lvl_on;
         if (n == now_t)      bus.trigger_now_i = 1'b1;
         else                 bus.trigger_now_i = 1'b0;
         if (n == stop_s)     bus.adc_capture_stop = 1'b1;
         if (n == abort_a)    bus.arm_i = 1'b0;
         if (n == e && e < a) bus.offset_i = $urandom;
      end
      tout_carry        = exp_tout;
      bus.trigger_now_i = 1'b0;
   endtask

   task automatic test_reset();
      rst                  = 1'b1;
      bus.arm_i            = 1'b0;
      bus.trig_mode_i      = 2'b00;
      bus.trigger_i        = 1'b0;
      bus.trigger_now_i    = 1'b0;
      bus.offset_i         = '0;
      bus.timeout_i        = '0;
      bus.adc_capture_stop = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.state_o, bus.adc_capture_go, bus.armed_o, bus.capture_done_o, bus.timed_out_o,
           bus.adc_trig_status} !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs got state=%0d go=%b armed=%b done=%b tout=%b status=%b exp all 0",
                  bus.state_o, bus.adc_capture_go, bus.armed_o, bus.capture_done_o,
                  bus.timed_out_o, bus.adc_trig_status);
      end
      rst = 1'b0;
      tout_carry = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.state_o !== S_IDLE) begin
         errors++;
         $display("FAIL reset_release state got %0d exp %0d", bus.state_o, S_IDLE);
      end
   endtask

   task automatic test_edge_trigger();
      run_scenario("edge_rise", 2'b00, 0, 2, -1, 0, 0, 16, -1, 0);
      run_scenario("edge_fall", 2'b01, 0, 3, -1, 0, 0, 12, -1, 0);
   endtask

   task automatic test_offset();
      run_scenario("offset5", 2'b00, 0, 2, -1, 5, 0, 21, -1, 0);
   endtask

   task automatic test_timeout();
      run_scenario("timeout100", 2'b00, 0, -1, -1, 0, 100, 111, -1, 0);
      run_scenario("rearm_clear", 2'b00, 0, -1, 3, 0, 0, 10, -1, 0);
      run_scenario("trig_vs_timeout", 2'b00, 0, -1, 5, 0, 5, 12, -1, 0);
   endtask

   task automatic test_stop_blank();
      run_scenario("stop_blank", 2'b00, 0, -1, 3, 0, 0, 0, -1, 0);
   endtask

   task automatic test_abort();
      run_scenario("abort_armed", 2'b00, 0, -1, -1, 0, 0, -1, 5, 0);
      run_scenario("abort_offset", 2'b00, 0, -1, 2, 20, 0, -1, 10, 0);
      run_scenario("abort_capture", 2'b00, 0, -1, 2, 0, 0, -1, 10, 0);
   endtask

   task automatic test_level_pre();
      run_scenario("level_high_pre", 2'b10, 1, -1, -1, 0, 0, 20, -1, 0);
      run_scenario("level_low_pre", 2'b11, 1, -1, -1, 3, 0, 20, -1, 0);
      run_scenario("edge_pre_waits", 2'b00, 0, -1, 8, 0, 0, 15, -1, 0);
   endtask

   task automatic test_held_arm();
      run_scenario("held_arm_done", 2'b00, 0, -1, 2, 0, 0, 10, -1, 60);
   endtask

   task automatic test_big_offset();
      run_scenario("big_offset", 2'b00, 0, -1, 2, 64'sd4294967295, 0, -1, 80, 0);
   endtask

   task automatic test_random();
      logic [1:0] mode;
      bit         pre;
      longint     pin_t, now_t, offset, timeout, stop_s, abort_a;
      for (int i = 0; i < 25; i++) begin
         mode    = 2'($urandom_range(0, 3));
         pre     = mode[1] && ($urandom_range(0, 3) == 0);
         pin_t   = (!pre && $urandom_range(0, 2) != 0) ? longint'($urandom_range(0, 15)) : -1;
         now_t   = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(1, 20)) : -1;
         offset  = ($urandom_range(0, 1) == 1) ? longint'($urandom_range(1, 8)) : 0;
         timeout = ($urandom_range(0, 2) == 0) ? longint'($urandom_range(1, 30)) : 0;
         stop_s  = longint'($urandom_range(0, 50));
         abort_a = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(1, 60)) : -1;
         if (pin_t < 0 && now_t < 0 && !pre && timeout == 0) now_t = longint'($urandom_range(1, 10));
         run_scenario("random", mode, pre, pin_t, now_t, offset, timeout, stop_s, abort_a, 0);
      end
   endtask

   task automatic test_reset_mid_capture();
      bit seen_go;
      @(negedge clk);
      bus.arm_i            = 1'b0;
      bus.trig_mode_i      = 2'b10;
      bus.trigger_i        = 1'b0;
      bus.offset_i         = '0;
      bus.timeout_i        = '0;
      bus.adc_capture_stop = 1'b0;
      repeat (5) @(negedge clk);
      bus.trigger_i = 1'b1;
      repeat (4) @(negedge clk);
      bus.arm_i = 1'b1;
      seen_go = 1'b0;
      for (int k = 0; k < 10 && !seen_go; k++) begin
         @(negedge clk);
         seen_go = bus.adc_capture_go;
      end
      checks++;
      if (!seen_go) begin
         errors++;
         $display("FAIL mid_reset_go_wait got go=0 exp go=1 within 10 cycles");
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({bus.state_o, bus.adc_capture_go, bus.armed_o, bus.capture_done_o, bus.timed_out_o,
           bus.adc_trig_status} !== 8'h00) begin
         errors++;
         $display("FAIL mid_reset_async got state=%0d go=%b armed=%b done=%b tout=%b status=%b exp all 0",
                  bus.state_o, bus.adc_capture_go, bus.armed_o, bus.capture_done_o,
                  bus.timed_out_o, bus.adc_trig_status);
      end
      @(negedge clk);
      bus.arm_i = 1'b0;
      rst       = 1'b0;
      tout_carry = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.state_o !== S_IDLE || bus.adc_capture_go !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_after got state=%0d go=%b exp state=0 go=0", bus.state_o, bus.adc_capture_go);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_edge_trigger();
      test_offset();
      test_timeout();
      test_stop_blank();
      test_abort();
      test_level_pre();
      test_held_arm();
      test_big_offset();
      test_random();
      test_reset_mid_capture();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
